lr_useq: RTL and testbench
==========================

// Module: lr_useq
// PURPOSE
//  Parametrised microcode sequencer for the lr35902 core. It owns the micro-PC, a micro-subroutine
//  return stack, memory wait-state stalls, HALT and interrupt entry (IME, EI delay, vectoring).
//  It sits between lr_ucode (ROM) and the datapath, and replaces the fixed next-address feedback.
// PARAMETERS
//  UADDR_W      16       micro-address width
//  STACK_DEPTH  4        return-stack entries (>=1)
//  NUM_IRQ      5        interrupt sources; index 0 has the highest priority
//  RESET_UADDR  16'h0000 micro-address loaded on reset
//  ISR_UADDR    16'h0010 micro-routine entered on interrupt accept
//  VEC_BASE     16'h0040 vector of irq 0
//  VEC_STRIDE   16'h0008 vector spacing between sources
// PORTS
//  clock4     in   1        core clock; all state updates on posedge
//  resetn     in   1        asynchronous, active-low reset
//  uc_next    in   UADDR_W  sequential successor from ROM
//  uc_jump    in   UADDR_W  branch/dispatch target (opcode dispatch on FETCH)
//  seq_op     in   3        0 NEXT,1 JUMP,2 CALL,3 RET,4 FETCH,5 HALT,6 EI,7 DI
//  mem_req    in   1        current microinstruction performs load/store
//  mem_ready  in   1        memory completes access this cycle
//  irq_req    in   NUM_IRQ  level requests (already IF&IE masked)
//  uaddr      out  UADDR_W  current micro-address, registered
//  stall      out  1        mem_req & ~mem_ready while RUN (combinational)
//  halted     out  1        state==HALT
//  ime        out  1        interrupt master enable
//  irq_ack    out  NUM_IRQ  one-cycle one-hot pulse for the accepted source
//  irq_vector out  16       VEC_BASE+idx*VEC_STRIDE of the last accepted irq; held until next accept
//  stack_err  out  1        sticky overflow/underflow flag; cleared only by reset
// BEHAVIOUR
//  Reset: uaddr=RESET_UADDR, state RUN, ime=0, ime_pend=0, stack empty, irq_ack=0,
//   irq_vector=VEC_BASE, stack_err=0, stall=0.
//  States: RUN, HALT. In RUN, an op advances only when stall=0; a stalled cycle holds all state.
//   NEXT: uaddr<=uc_next. JUMP: uaddr<=uc_jump.
//   CALL: push uc_next, uaddr<=uc_jump. Full stack: push dropped, stack_err<=1, jump still taken.
//   RET: uaddr<=pop. Empty stack: uaddr<=uc_next, stack_err<=1.
//   FETCH: if ime & |irq_req: accept lowest set index i; irq_ack[i]=1 for 1 cycle; ime<=0;
//    ime_pend<=0; irq_vector<=VEC_BASE+i*VEC_STRIDE; uaddr<=ISR_UADDR.
//    Otherwise uaddr<=uc_jump, and ime_pend promotes (ime<=1, ime_pend<=0) after this check.
//    The EI delay is therefore exactly one instruction.
//   HALT: |irq_req==0 -> state HALT, uaddr holds. Pending irq -> HALT acts as NEXT (no halt).
//   EI: ime_pend<=1, uaddr<=uc_next. DI: ime<=0, ime_pend<=0, uaddr<=uc_next.
//  HALT: exits the cycle after |irq_req is seen, regardless of ime; state<=RUN.
//   ime=1: accept as on FETCH. ime=0: uaddr<=uc_next, no ack.
//   mem_req is ignored in HALT; stall=0.
//  irq_req is sampled only on an unstalled FETCH, or on a HALT exit; changes during a stall have no effect.
//  Latency: accept to ISR_UADDR on uaddr is 1 cycle; irq_ack is asserted in the same cycle as the update.
//  Stack pointer is clog2(STACK_DEPTH+1) bits and saturates; no wrap-around.
//  Asynchronous reset mid-stall, mid-HALT or mid-ack returns everything to the reset values immediately.
// STRUCTURE
//  lr_pkg: SEQ_NEXT..SEQ_DI opcodes, ST_RUN/ST_HALT encodings, shared by lr_ucode and lr_useq.
//  Sub-module lr_ustack (UADDR_W, STACK_DEPTH): push/pop/full/empty LIFO with async reset.
//  The priority encoder for irq selection is a function in lr_pkg.
// TESTING
//  Sequencing: NEXT uc_next=5, then JUMP uc_jump=0x20 -> uaddr 5 then 0x20.
//  Stall: mem_req=1, mem_ready=0 for 3 cycles -> stall=1, uaddr frozen. ready=1 -> advances once.
//  Stack: 4 CALLs then a 5th -> stack_err=1. 4 RETs return in LIFO order. Extra RET -> uaddr=uc_next.
//  EI delay: EI, FETCH with irq_req=1 -> dispatch to uc_jump, no ack.
//   Next FETCH -> irq_ack=00001, uaddr=0x10, irq_vector=0x40, ime=0.
//  Priority: ime=1, irq_req=10100 at FETCH -> irq_ack=00100, irq_vector=0x50.
//  HALT: ime=0, halt 10 cycles -> halted=1, uaddr held. irq_req[3]=1 -> halted=0, uaddr=uc_next, no ack.
//   Repeat with ime=1 -> ack 01000, vector 0x58.
//  Reset asserted mid-HALT -> uaddr=0, halted=0, ime=0 asynchronously.

Source files
------------

// File: rtl/lr_pkg.sv
// Shared encodings for the lr35902 microcode sequencer and ROM: sequencer opcodes,
// sequencer states and the interrupt priority encoder.
package lr_pkg;

  typedef enum logic [2:0] {
    SEQ_NEXT  = 3'd0,
    SEQ_JUMP  = 3'd1,
    SEQ_CALL  = 3'd2,
    SEQ_RET   = 3'd3,
    SEQ_FETCH = 3'd4,
    SEQ_HALT  = 3'd5,
    SEQ_EI    = 3'd6,
    SEQ_DI    = 3'd7
  } seq_op_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  // Widest request vector the encoder handles; narrower vectors are zero-extended.
  localparam int MAX_IRQ = 32;

  // Lowest set index wins (index 0 is the highest priority).
  function automatic logic [4:0] irq_prio(input logic [MAX_IRQ-1:0] req);
    logic [4:0] idx;
    idx = '0;
    for (int i = MAX_IRQ - 1; i >= 0; i--) begin
      if (req[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/lr_ustack.sv
// Micro-subroutine return stack: a small LIFO with a saturating pointer.
// Push when full and pop when empty are ignored; the caller flags the error.
module lr_ustack #(
  parameter int UADDR_W     = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic               clock4,
  input  logic               resetn,
  input  logic               push,
  input  logic               pop,
  input  logic [UADDR_W-1:0] push_data,
  output logic [UADDR_W-1:0] pop_data,
  output logic               full,
  output logic               empty
);

  localparam int SP_W = $clog2(STACK_DEPTH + 1);

  logic [SP_W-1:0]    sp;
  logic [UADDR_W-1:0] mem [2**SP_W];

  assign full     = (sp == SP_W'(STACK_DEPTH));
  assign empty    = (sp == '0);
  assign pop_data = mem[sp - SP_W'(1)];

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clock4 or negedge resetn) begin
    if (!resetn)              sp <= '0;
    else if (push && !full)   sp <= sp + SP_W'(1);
    else if (pop && !empty)   sp <= sp - SP_W'(1);
  end

  // NOTE: the storage array is not reset; sp alone defines which entries are valid.
  always_ff @(posedge clock4) begin
    if (push && !full) mem[sp] <= push_data;
  end

endmodule

// File: rtl/lr_useq.sv
// Microcode sequencer: micro-PC, return stack, memory stalls, HALT and interrupt
// entry with IME and the one-instruction EI delay.
module lr_useq
  import lr_pkg::*;
#(
  parameter int                 UADDR_W     = 16,
  parameter int                 STACK_DEPTH = 4,
  parameter int                 NUM_IRQ     = 5,
  parameter logic [UADDR_W-1:0] RESET_UADDR = 16'h0000,
  parameter logic [UADDR_W-1:0] ISR_UADDR   = 16'h0010,
  parameter logic [15:0]        VEC_BASE    = 16'h0040,
  parameter logic [15:0]        VEC_STRIDE  = 16'h0008
) (
  input  logic               clock4,
  input  logic               resetn,
  input  logic [UADDR_W-1:0] uc_next,
  input  logic [UADDR_W-1:0] uc_jump,
  input  logic [2:0]         seq_op,
  input  logic               mem_req,
  input  logic               mem_ready,
  input  logic [NUM_IRQ-1:0] irq_req,
  output logic [UADDR_W-1:0] uaddr,
  output logic               stall,
  output logic               halted,
  output logic               ime,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic [15:0]        irq_vector,
  output logic               stack_err
);

  state_e             state, state_d;
  logic [UADDR_W-1:0] uaddr_d;
  logic               ime_d, ime_pend, ime_pend_d, stack_err_d;
  logic [NUM_IRQ-1:0] irq_ack_d;
  logic [15:0]        irq_vector_d;
  logic               push, pop, full, empty, accept, irq_any;
  logic [UADDR_W-1:0] pop_data;
  logic [MAX_IRQ-1:0] irq_pad;
  logic [4:0]         irq_idx;

  lr_ustack #(
    .UADDR_W     (UADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clock4    (clock4),
    .resetn    (resetn),
    .push      (push),
    .pop       (pop),
    .push_data (uc_next),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (empty)
  );

  assign irq_pad = MAX_IRQ'(irq_req);
  assign irq_idx = irq_prio(irq_pad);
  assign irq_any = |irq_req;
  assign stall   = (state == ST_RUN) && mem_req && !mem_ready;
  assign halted  = (state == ST_HALT);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state;
    uaddr_d      = uaddr;
    ime_d        = ime;
    ime_pend_d   = ime_pend;
    stack_err_d  = stack_err;
    irq_ack_d    = '0;
    irq_vector_d = irq_vector;
    push         = 1'b0;
    pop          = 1'b0;
    accept       = 1'b0;

    case (state)
      ST_RUN: begin
        if (!stall) begin
          case (seq_op_e'(seq_op))
            SEQ_NEXT: uaddr_d = uc_next;
            SEQ_JUMP: uaddr_d = uc_jump;
            SEQ_CALL: begin
              uaddr_d = uc_jump;
              if (full) stack_err_d = 1'b1;
              else      push        = 1'b1;
            end
            SEQ_RET: begin
              if (empty) begin
                uaddr_d     = uc_next;
                stack_err_d = 1'b1;
              end else begin
                uaddr_d = pop_data;
                pop     = 1'b1;
              end
            end
            SEQ_FETCH: begin
              // A pending EI only takes effect after this boundary has been checked.
              if (ime && irq_any) begin
                accept = 1'b1;
              end else begin
                uaddr_d = uc_jump;
                if (ime_pend) begin
                  ime_d      = 1'b1;
                  ime_pend_d = 1'b0;
                end
              end
            end
            SEQ_HALT: begin
              if (irq_any) uaddr_d = uc_next;
              else         state_d = ST_HALT;
            end
            SEQ_EI: begin
              ime_pend_d = 1'b1;
              uaddr_d    = uc_next;
            end
            SEQ_DI: begin
              ime_d      = 1'b0;
              ime_pend_d = 1'b0;
              uaddr_d    = uc_next;
            end
          endcase
        end
      end
      ST_HALT: begin
        if (irq_any) begin
          state_d = ST_RUN;
          if (ime) accept  = 1'b1;
          else     uaddr_d = uc_next;
        end
      end
    endcase

    if (accept) begin
      irq_ack_d    = NUM_IRQ'(1) << irq_idx;
      ime_d        = 1'b0;
      ime_pend_d   = 1'b0;
      irq_vector_d = VEC_BASE + 16'(irq_idx) * VEC_STRIDE;
      uaddr_d      = ISR_UADDR;
    end
  end

  always_ff @(posedge clock4 or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_RUN;
      uaddr      <= RESET_UADDR;
      ime        <= 1'b0;
      ime_pend   <= 1'b0;
      stack_err  <= 1'b0;
      irq_ack    <= '0;
      irq_vector <= VEC_BASE;
    end else begin
      state      <= state_d;
      uaddr      <= uaddr_d;
      ime        <= ime_d;
      ime_pend   <= ime_pend_d;
      stack_err  <= stack_err_d;
      irq_ack    <= irq_ack_d;
      irq_vector <= irq_vector_d;
    end
  end

endmodule

// File: tb/tb_lr_useq.sv
// Self-checking bench for lr_useq: expected micro-addresses go into a scoreboard
// queue as each op is driven and are popped once the DUT has taken the edge.
module tb_lr_useq;
  import lr_pkg::*;

  logic        clock4 = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] uc_next = '0, uc_jump = '0;
  logic [2:0]  seq_op = 3'd0;
  logic        mem_req = 1'b0, mem_ready = 1'b1;
  logic [4:0]  irq_req = '0;
  logic [15:0] uaddr;
  logic        stall, halted, ime, stack_err;
  logic [4:0]  irq_ack;
  logic [15:0] irq_vector;

  int          checks = 0;
  int          passes = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_u;

  lr_useq dut (
    .clock4     (clock4),
    .resetn     (resetn),
    .uc_next    (uc_next),
    .uc_jump    (uc_jump),
    .seq_op     (seq_op),
    .mem_req    (mem_req),
    .mem_ready  (mem_ready),
    .irq_req    (irq_req),
    .uaddr      (uaddr),
    .stall      (stall),
    .halted     (halted),
    .ime        (ime),
    .irq_ack    (irq_ack),
    .irq_vector (irq_vector),
    .stack_err  (stack_err)
  );

  always #5 clock4 = ~clock4;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock4);
    #1;
  endtask

  // Drives one microinstruction and lets the DUT take one edge; expectations are pushed beforehand.
  task automatic drive(input seq_op_e op, input logic [15:0] nxt, input logic [15:0] jmp);
    seq_op  = op;
    uc_next = nxt;
    uc_jump = jmp;
    step();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    seq_op = SEQ_NEXT;
    irq_req = '0;
    mem_req = 1'b0;
    step();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (uaddr !== 16'h0000) $display("FAIL reset_uaddr got=%h exp=0000", uaddr); else passes++;
    checks++; if ({halted, ime, stack_err, stall} !== 4'b0000)
      $display("FAIL reset_flags got=%b exp=0000", {halted, ime, stack_err, stall}); else passes++;
    checks++; if (irq_ack !== 5'b0) $display("FAIL reset_ack got=%b exp=00000", irq_ack); else passes++;
    checks++; if (irq_vector !== 16'h0040) $display("FAIL reset_vector got=%h exp=0040", irq_vector); else passes++;
  endtask

  task automatic test_sequencing();
    exp_q.push_back(16'h0005);
    drive(SEQ_NEXT, 16'h0005, 16'h0099);
    exp_u = exp_q.pop_front();
    checks++; if (uaddr !== exp_u) $display("FAIL seq_next got=%h exp=%h", uaddr, exp_u); else passes++;
    exp_q.push_back(16'h0020);
    drive(SEQ_JUMP, 16'h0006, 16'h0020);
    exp_u = exp_q.pop_front();
    checks++; if (uaddr !== exp_u) $display("FAIL seq_jump got=%h exp=%h", uaddr, exp_u); else passes++;
  endtask

  task automatic test_stall();
    mem_req   = 1'b1;
    mem_ready = 1'b0;
    seq_op    = SEQ_NEXT;
    uc_next   = 16'h0033;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (stall !== 1'b1) $display("FAIL stall_flag cyc=%0d got=%b exp=1", i, stall); else passes++;
      exp_q.push_back(16'h0020);
      step();
      exp_u = exp_q.pop_front();
      checks++; if (uaddr !== exp_u) $display("FAIL stall_hold cyc=%0d got=%h exp=%h", i, uaddr, exp_u); else passes++;
    end
    mem_ready = 1'b1;
    exp_q.push_back(16'h0033);
    step();
    exp_u = exp_q.pop_front();
    checks++; if (uaddr !== exp_u) $display("FAIL stall_release got=%h exp=%h", uaddr, exp_u); else passes++;
    mem_req = 1'b0;
  endtask

  task automatic test_stack();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(16'(16'h0200 + i));
      drive(SEQ_CALL, 16'(16'h0100 + i), 16'(16'h0200 + i));
      exp_u = exp_q.pop_front();
      checks++; if (uaddr !== exp_u) $display("FAIL call_%0d got=%h exp=%h", i, uaddr, exp_u); else passes++;
    end
    checks++; if (stack_err !== 1'b0) $display("FAIL stack_err_early got=%b exp=0", stack_err); else passes++;
    exp_q.push_back(16'h0300);
    drive(SEQ_CALL, 16'h01FF, 16'h0300);
    exp_u = exp_q.pop_front();
    checks++; if (uaddr !== exp_u) $display("FAIL call_overflow got=%h exp=%h", uaddr, exp_u); else passes++;
    checks++; if (stack_err !== 1'b1) $display("FAIL stack_err_overflow got=%b exp=1", stack_err); else passes++;
    for (int i = 3; i >= 0; i--) exp_q.push_back(16'(16'h0100 + i));
    for (int i = 0; i < 4; i++) begin
      drive(SEQ_RET, 16'h0555, 16'h0666);
      exp_u = exp_q.pop_front();
      checks++; if (uaddr !== exp_u) $display("FAIL ret_%0d got=%h exp=%h", i, uaddr, exp_u); else passes++;
    end
    exp_q.push_back(16'h0777);
    drive(SEQ_RET, 16'h0777, 16'h0888);
    exp_u = exp_q.pop_front();
    checks++; if (uaddr !== exp_u) $display("FAIL ret_underflow got=%h exp=%h", uaddr, exp_u); else passes++;
    checks++; if (stack_err !== 1'b1) $display("FAIL stack_err_sticky got=%b exp=1", stack_err); else passes++;
  endtask

  task automatic test_ei_delay();
    do_reset();
    exp_q.push_back(16'h0050);
    drive(SEQ_EI, 16'h0050, 16'h0000);
    exp_u = exp_q.pop_front();
    checks++; if (uaddr !== exp_u) $display("FAIL ei_uaddr got=%h exp=%h", uaddr, exp_u); else passes++;
    checks++; if (ime !== 1'b0) $display("FAIL ei_ime_delayed got=%b exp=0", ime); else passes++;
    irq_req = 5'b00001;
    exp_q.push_back(16'h0060);
    drive(SEQ_FETCH, 16'h0000, 16'h0060);
    exp_u = exp_q.pop_front();
    checks++; if (uaddr !== exp_u) $display("FAIL ei_first_fetch got=%h exp=%h", uaddr, exp_u); else passes++;
    checks++; if (irq_ack !== 5'b0) $display("FAIL ei_no_ack got=%b exp=00000", irq_ack); else passes++;
    checks++; if (ime !== 1'b1) $display("FAIL ei_ime_set got=%b exp=1", ime); else passes++;
    exp_q.push_back(16'h0010);
    drive(SEQ_FETCH, 16'h0000, 16'h0070);
    exp_u = exp_q.pop_front();
    checks++; if (uaddr !== exp_u) $display("FAIL irq0_uaddr got=%h exp=%h", uaddr, exp_u); else passes++;
    checks++; if (irq_ack !== 5'b00001) $display("FAIL irq0_ack got=%b exp=00001", irq_ack); else passes++;
    checks++; if (irq_vector !== 16'h0040) $display("FAIL irq0_vector got=%h exp=0040", irq_vector); else passes++;
    checks++; if (ime !== 1'b0) $display("FAIL irq0_ime got=%b exp=0", ime); else passes++;
    irq_req = '0;
    exp_q.push_back(16'h0011);
    drive(SEQ_NEXT, 16'h0011, 16'h0000);
    exp_u = exp_q.pop_front();
    checks++; if (uaddr !== exp_u) $display("FAIL isr_next got=%h exp=%h", uaddr, exp_u); else passes++;
    checks++; if (irq_ack !== 5'b0) $display("FAIL ack_pulse got=%b exp=00000", irq_ack); else passes++;
  endtask

  task automatic test_priority();
    drive(SEQ_EI, 16'h0012, 16'h0000);
    drive(SEQ_FETCH, 16'h0000, 16'h0013);
    checks++; if (ime !== 1'b1) $display("FAIL prio_ime got=%b exp=1", ime); else passes++;
    irq_req = 5'b10100;
    exp_q.push_back(16'h0010);
    drive(SEQ_FETCH, 16'h0000, 16'h0014);
    exp_u = exp_q.pop_front();
    checks++; if (uaddr !== exp_u) $display("FAIL prio_uaddr got=%h exp=%h", uaddr, exp_u); else passes++;
    checks++; if (irq_ack !== 5'b00100) $display("FAIL prio_ack got=%b exp=00100", irq_ack); else passes++;
    checks++; if (irq_vector !== 16'h0050) $display("FAIL prio_vector got=%h exp=0050", irq_vector); else passes++;
    irq_req = '0;
  endtask

  task automatic test_halt();
    drive(SEQ_NEXT, 16'h0030, 16'h0000);
    exp_q.push_back(16'h0030);
    drive(SEQ_HALT, 16'h0099, 16'h0000);
    exp_u = exp_q.pop_front();
    checks++; if (uaddr !== exp_u) $display("FAIL halt_enter got=%h exp=%h", uaddr, exp_u); else passes++;
    checks++; if (halted !== 1'b1) $display("FAIL halt_flag got=%b exp=1", halted); else passes++;
    mem_req   = 1'b1;
    mem_ready = 1'b0;
    for (int i = 0; i < 9; i++) drive(SEQ_NEXT, 16'h0099, 16'h0098);
    checks++; if ({halted, uaddr} !== {1'b1, 16'h0030})
      $display("FAIL halt_hold got=%b/%h exp=1/0030", halted, uaddr); else passes++;
    checks++; if (stall !== 1'b0) $display("FAIL halt_no_stall got=%b exp=0", stall); else passes++;
    irq_req = 5'b01000;
    exp_q.push_back(16'h0031);
    drive(SEQ_NEXT, 16'h0031, 16'h0098);
    exp_u = exp_q.pop_front();
    irq_req = '0;
    mem_req = 1'b0;
    mem_ready = 1'b1;
    checks++; if (uaddr !== exp_u) $display("FAIL halt_exit_noime got=%h exp=%h", uaddr, exp_u); else passes++;
    checks++; if ({halted, irq_ack} !== 6'b0) $display("FAIL halt_exit_noack got=%b/%b exp=0/00000", halted, irq_ack); else passes++;

    drive(SEQ_EI, 16'h0032, 16'h0000);
    drive(SEQ_FETCH, 16'h0000, 16'h0033);
    drive(SEQ_HALT, 16'h0034, 16'h0000);
    drive(SEQ_NEXT, 16'h0035, 16'h0000);
    drive(SEQ_NEXT, 16'h0035, 16'h0000);
    checks++; if ({halted, ime} !== 2'b11) $display("FAIL halt_ime_hold got=%b exp=11", {halted, ime}); else passes++;
    irq_req = 5'b01000;
    exp_q.push_back(16'h0010);
    drive(SEQ_NEXT, 16'h0036, 16'h0000);
    exp_u = exp_q.pop_front();
    irq_req = '0;
    checks++; if (uaddr !== exp_u) $display("FAIL halt_isr_uaddr got=%h exp=%h", uaddr, exp_u); else passes++;
    checks++; if (irq_ack !== 5'b01000) $display("FAIL halt_isr_ack got=%b exp=01000", irq_ack); else passes++;
    checks++; if (irq_vector !== 16'h0058) $display("FAIL halt_isr_vector got=%h exp=0058", irq_vector); else passes++;
    checks++; if ({halted, ime} !== 2'b00) $display("FAIL halt_isr_flags got=%b exp=00", {halted, ime}); else passes++;

    irq_req = 5'b00010;
    exp_q.push_back(16'h0044);
    drive(SEQ_HALT, 16'h0044, 16'h0000);
    exp_u = exp_q.pop_front();
    irq_req = '0;
    checks++; if ({halted, uaddr} !== {1'b0, exp_u})
      $display("FAIL halt_pending got=%b/%h exp=0/%h", halted, uaddr, exp_u); else passes++;
  endtask

  task automatic test_reset_mid_halt();
    drive(SEQ_EI, 16'h0060, 16'h0000);
    drive(SEQ_FETCH, 16'h0000, 16'h0061);
    drive(SEQ_HALT, 16'h0062, 16'h0000);
    drive(SEQ_NEXT, 16'h0063, 16'h0000);
    checks++; if ({halted, ime} !== 2'b11) $display("FAIL pre_reset got=%b exp=11", {halted, ime}); else passes++;
    #2;
    resetn = 1'b0;
    #1;
    checks++; if (uaddr !== 16'h0000) $display("FAIL async_reset_uaddr got=%h exp=0000", uaddr); else passes++;
    checks++; if ({halted, ime, stack_err} !== 3'b000)
      $display("FAIL async_reset_flags got=%b exp=000", {halted, ime, stack_err}); else passes++;
    step();
    resetn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_sequencing();
    test_stall();
    test_stack();
    test_ei_delay();
    test_priority();
    test_halt();
    test_reset_mid_halt();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
